// File: rtl/riscv_mul_ctrl.sv
// Sequencer between execute and the 33x33 signed multi-cycle multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Issues one request per op, returns the selected half, and replays repeated operands from a one-entry cache.
module riscv_mul_ctrl #(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        kill_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        mreq_o,
    output logic [32:0] ma_o,
    output logic [32:0] mb_o,
    output logic        mzf_o,
    input  logic        mrdy_i,
    input  logic [63:0] mres_i,
    output logic [15:0] hit_cnt_o
);

    // Handshake: an op transfers on a cycle where valid_i & ready_o & ~kill_i;
    // the result is a one-cycle valid_o pulse with no backpressure.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIT   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    state_t      state_q;
    logic [1:0]  op_q;
    logic        cache_vld_q;
    logic [32:0] key_a_q;
    logic [32:0] key_b_q;
    logic [63:0] prod_q;

    logic [32:0] a_ext;
    logic [32:0] b_ext;
    logic        zf;
    logic        accept;
    logic        hit;

    always_comb begin
        a_ext = {1'b0, rs1_i};
        b_ext = {1'b0, rs2_i};
        case (op_i)
            OP_MUL, OP_MULH: begin
                a_ext = {rs1_i[31], rs1_i};
                b_ext = {rs2_i[31], rs2_i};
            end
            OP_MULHSU: begin
                a_ext = {rs1_i[31], rs1_i};
                b_ext = {1'b0, rs2_i};
            end
            default: begin
                a_ext = {1'b0, rs1_i};
                b_ext = {1'b0, rs2_i};
            end
        endcase
    end

    assign zf      = (rs1_i == 32'd0) | (rs2_i == 32'd0);
    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q != IDLE);
    assign accept  = ready_o & valid_i & ~kill_i;

    // The key is the extended operand pair, so MUL and MULH on the same registers share a product.
    assign hit = CACHE_EN & cache_vld_q & (key_a_q == a_ext) & (key_b_q == b_ext);

    function automatic logic [31:0] sel_half(input logic [1:0] op, input logic [63:0] p);
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            cache_vld_q <= 1'b0;
            key_a_q     <= '0;
            key_b_q     <= '0;
            prod_q      <= '0;
            valid_o     <= 1'b0;
            result_o    <= '0;
            mreq_o      <= 1'b0;
            ma_o        <= '0;
            mb_o        <= '0;
            mzf_o       <= 1'b0;
            hit_cnt_o   <= '0;
        end else begin
            valid_o <= 1'b0;
            mreq_o  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            valid_o  <= 1'b1;
                            result_o <= sel_half(op_i, prod_q);
                            if (hit_cnt_o != 16'hFFFF) begin
                                hit_cnt_o <= hit_cnt_o + 16'd1;
                            end
                            state_q  <= HIT;
                        end else begin
                            ma_o    <= a_ext;
                            mb_o    <= b_ext;
                            mzf_o   <= zf;
                            mreq_o  <= 1'b1;
                            op_q    <= op_i;
                            state_q <= WAIT;
                        end
                    end
                end
                HIT: begin
                    state_q <= IDLE;
                end
                WAIT: begin
                    if (mrdy_i) begin
                        cache_vld_q <= 1'b1;
                        key_a_q     <= ma_o;
                        key_b_q     <= mb_o;
                        prod_q      <= mres_i;
                        if (!kill_i) begin
                            valid_o  <= 1'b1;
                            result_o <= sel_half(op_q, mres_i);
                        end
                        state_q <= IDLE;
                    end else if (kill_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The multiplier cannot be aborted; keep its product for a likely retry.
                    if (mrdy_i) begin
                        cache_vld_q <= 1'b1;
                        key_a_q     <= ma_o;
                        key_b_q     <= mb_o;
                        prod_q      <= mres_i;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mul_ctrl.sv
// Directed bench for riscv_mul_ctrl with a behavioural multi-cycle multiplier responding to mreq_o.
module tb_riscv_mul_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        kill_i = 1'b0;
    logic        ready_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        mreq_o;
    logic [32:0] ma_o;
    logic [32:0] mb_o;
    logic        mzf_o;
    logic        mrdy_i = 1'b0;
    logic [63:0] mres_i = '0;
    logic [15:0] hit_cnt_o;

    int checks = 0;
    int failures = 0;
    int mreq_cnt = 0;
    int stab_err = 0;

    logic [32:0] cap_a = '0;
    logic [32:0] cap_b = '0;
    logic        cap_zf = 1'b0;
    logic [63:0] prod = '0;
    int          pend = 0;
    int          cd = 0;
    logic        rst_seen = 1'b1;
    logic [31:0] last_res = '0;

    riscv_mul_ctrl #(.CACHE_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .kill_i(kill_i), .ready_o(ready_o),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .mreq_o(mreq_o),
        .ma_o(ma_o), .mb_o(mb_o), .mzf_o(mzf_o), .mrdy_i(mrdy_i), .mres_i(mres_i),
        .hit_cnt_o(hit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Multiplier model: zero flag answers 1 cycle after req, small operands 3, otherwise 5.
    function automatic int mul_delay(input logic [32:0] a, input logic [32:0] b, input logic z);
        logic [32:0] aa;
        logic [32:0] ab;
        aa = a[32] ? (~a + 33'd1) : a;
        ab = b[32] ? (~b + 33'd1) : b;
        if (z) return 1;
        if (aa < 33'h40000 && ab < 33'h40000) return 3;
        return 5;
    endfunction

    always @(posedge clk_i) rst_seen <= rst_i;

    always @(negedge clk_i) begin
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] p;
        mrdy_i = 1'b0;
        if (rst_seen) begin
            pend = 0;
        end else begin
            if (pend != 0) begin
                if (ma_o !== cap_a || mb_o !== cap_b || mzf_o !== cap_zf) stab_err++;
                if (cd == 1) begin
                    mrdy_i = 1'b1;
                    mres_i = prod;
                    pend = 0;
                end else begin
                    cd--;
                end
            end
            if (mreq_o) begin
                mreq_cnt++;
                pend = 1;
                cap_a = ma_o;
                cap_b = mb_o;
                cap_zf = mzf_o;
                sa = {{33{ma_o[32]}}, ma_o};
                sb = {{33{mb_o[32]}}, mb_o};
                p = sa * sb;
                prod = p[63:0];
                cd = mul_delay(ma_o, mb_o, mzf_o);
            end
        end
    end

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int w;
        int lat_seen;
        @(negedge clk_i);
        check({tag, "_held"}, {32'd0, result_o}, {32'd0, last_res});
        w = 0;
        while (!ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        check({tag, "_ready"}, {63'd0, ready_o}, 64'd1);
        valid_i = 1'b1;
        op_i = op;
        rs1_i = a;
        rs2_i = b;
        lat_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_i);
            if (k == 1) valid_i = 1'b0;
            if (valid_o) begin
                lat_seen = k;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat_seen), 64'(exp_lat));
        check({tag, "_res"}, {32'd0, result_o}, {32'd0, exp_res});
        @(negedge clk_i);
        check({tag, "_pulse"}, {63'd0, valid_o}, 64'd0);
        last_res = exp_res;
    endtask

    initial begin
        int m0;
        int vcnt;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_ready", {63'd0, ready_o}, 64'd1);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_mreq", {63'd0, mreq_o}, 64'd0);
        check("rst_result", {32'd0, result_o}, 64'd0);
        check("rst_ma_mb", {ma_o[31:0], mb_o[31:0]}, 64'd0);
        check("rst_mzf", {63'd0, mzf_o}, 64'd0);
        check("rst_hitcnt", {48'd0, hit_cnt_o}, 64'd0);

        // MUL 7 * -3, small operands
        m0 = mreq_cnt;
        run_op("mul_small", 2'b00, 32'd7, 32'hFFFFFFFD, 5, 32'hFFFFFFEB);
        check("mul_small_mreq", 64'(mreq_cnt - m0), 64'd1);
        check("mul_small_ma", {31'd0, cap_a}, 64'h0_00000007);
        check("mul_small_mb", {31'd0, cap_b}, 64'h1_FFFFFFFD);
        check("mul_small_mzf", {63'd0, cap_zf}, 64'd0);

        // MULH full multiply, then MUL on same operands hits
        run_op("mulh_full", 2'b01, 32'h80000000, 32'h80000000, 7, 32'h40000000);
        m0 = mreq_cnt;
        run_op("mul_hit", 2'b00, 32'h80000000, 32'h80000000, 1, 32'h00000000);
        check("mul_hit_mreq", 64'(mreq_cnt - m0), 64'd0);
        check("mul_hit_cnt", {48'd0, hit_cnt_o}, 64'd1);

        // MULHSU then MULHU: different extension, different key
        run_op("mulhsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 32'hFFFFFFFF);
        check("mulhsu_mb", {31'd0, cap_b}, 64'h0_FFFFFFFF);
        check("mulhsu_ma", {31'd0, cap_a}, 64'h1_FFFFFFFF);
        m0 = mreq_cnt;
        run_op("mulhu", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 32'hFFFFFFFE);
        check("mulhu_mreq", 64'(mreq_cnt - m0), 64'd1);

        // zero operand shortcut
        run_op("mulhsu_zero", 2'b10, 32'd0, 32'h12345678, 3, 32'd0);
        check("zero_mzf", {63'd0, cap_zf}, 64'd1);

        // kill at T+2 of a full multiply; a new op waits for the drain, then hits
        m0 = mreq_cnt;
        vcnt = 0;
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'h00040000; rs2_i = 32'd3;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            if (k == 1) valid_i = 1'b0;
            if (k == 2) kill_i = 1'b1;
            if (k == 3) begin
                kill_i = 1'b0;
                valid_i = 1'b1;
            end
            if (k == 6) check("kill_busy_drain", {63'd0, busy_o}, 64'd1);
            if (k == 7) check("kill_busy_done", {63'd0, busy_o}, 64'd0);
            if (k <= 7 && valid_o) vcnt++;
        end
        check("kill_no_valid", 64'(vcnt), 64'd0);
        check("kill_retry_valid", {63'd0, valid_o}, 64'd1);
        check("kill_retry_res", {32'd0, result_o}, 64'h000C0000);
        valid_i = 1'b0;
        check("kill_mreq", 64'(mreq_cnt - m0), 64'd1);
        @(negedge clk_i);
        check("kill_hitcnt", {48'd0, hit_cnt_o}, 64'd2);
        last_res = 32'h000C0000;

        // reset at T+3 of a full multiply
        vcnt = 0;
        valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'h00100000; rs2_i = 32'd5;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            if (k == 1) valid_i = 1'b0;
            if (k == 3) rst_i = 1'b1;
            if (k == 4) begin
                rst_i = 1'b0;
                check("rstmid_ready", {63'd0, ready_o}, 64'd1);
                check("rstmid_result", {32'd0, result_o}, 64'd0);
                check("rstmid_hitcnt", {48'd0, hit_cnt_o}, 64'd0);
            end
            if (valid_o) vcnt++;
        end
        check("rstmid_no_valid", 64'(vcnt), 64'd0);
        last_res = 32'd0;
        m0 = mreq_cnt;
        run_op("rstmid_retry", 2'b00, 32'h00100000, 32'd5, 7, 32'h00500000);
        check("rstmid_retry_mreq", 64'(mreq_cnt - m0), 64'd1);

        check("operand_stability", 64'(stab_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
